// File: rtl/jtag_master.sv
// rtl/jtag_master.sv - JTAG host controller: TAP reset, IR and DR scans over a valid/ready command port.
// The target TAP is parked in Run-Test/Idle between commands.
module jtag_master #(
  parameter int DWIDTH  = 32,
  parameter int CLK_DIV = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_reset,
  input  logic                      cmd_ir,
  input  logic [$clog2(DWIDTH)-1:0] cmd_len,
  input  logic [DWIDTH-1:0]         cmd_data,
  output logic                      rsp_valid,
  output logic [DWIDTH-1:0]         rsp_data,
  output logic                      tck,
  output logic                      tms,
  output logic                      tdi,
  input  logic                      tdo
);

  localparam int LW = $clog2(DWIDTH);
  localparam int BW = (LW > 3) ? LW : 3;
  localparam int CW = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0] CYC_RISE   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CYC_SAMPLE = CW'(CLK_DIV);
  localparam logic [CW-1:0] CYC_LAST   = CW'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {INIT, IDLE, HDR, SHIFT, TRAIL, DONE} state_t;

  state_t            state_q, state_d;
  logic              run_q, run_d;
  logic [CW-1:0]     cyc_q, cyc_d;
  logic [BW-1:0]     bit_q, bit_d, last_bit;
  logic              tck_d, tms_d, tdi_d;
  logic              rst_cmd_q, rst_cmd_d;
  logic              ir_q, ir_d;
  logic [LW-1:0]     len_q, len_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic [DWIDTH-1:0] cap_q, cap_d;
  logic [DWIDTH-1:0] rsp_d;
  logic              load;

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    cyc_d     = cyc_q;
    bit_d     = bit_q;
    tck_d     = tck;
    tms_d     = tms;
    tdi_d     = tdi;
    rst_cmd_d = rst_cmd_q;
    ir_d      = ir_q;
    len_d     = len_q;
    data_d    = data_q;
    cap_d     = cap_q;
    rsp_d     = rsp_data;
    load      = 1'b0;

    // Index of the final TCK of each TMS segment.
    case (state_q)
      INIT:    last_bit = BW'(5);
      HDR:     last_bit = ir_q ? BW'(3) : BW'(2);
      SHIFT:   last_bit = BW'(len_q);
      TRAIL:   last_bit = BW'(1);
      default: last_bit = '0;
    endcase

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d   = cmd_reset ? INIT : HDR;
          rst_cmd_d = cmd_reset;
          ir_d      = cmd_ir;
          len_d     = cmd_len;
          data_d    = cmd_data;
          cap_d     = '0;
          run_d     = 1'b1;
          cyc_d     = '0;
          bit_d     = '0;
          tck_d     = 1'b0;
          tms_d     = 1'b1;
          tdi_d     = 1'b0;
        end
      end
      DONE: state_d = IDLE;
      default: begin
        if (!run_q) begin
          // Leaving reset: the first INIT low phase starts next cycle.
          run_d = 1'b1;
          cyc_d = '0;
          bit_d = '0;
          tck_d = 1'b0;
          tms_d = 1'b1;
          tdi_d = 1'b0;
        end else begin
          cyc_d = cyc_q + CW'(1);
          if (cyc_q == CYC_RISE)
            tck_d = 1'b1;
          if (state_q == SHIFT && cyc_q == CYC_SAMPLE)
            cap_d[bit_q[LW-1:0]] = tdo;
          if (cyc_q == CYC_LAST) begin
            cyc_d = '0;
            tck_d = 1'b0;
            load  = 1'b1;
            if (bit_q == last_bit) begin
              bit_d = '0;
              case (state_q)
                INIT:    state_d = rst_cmd_q ? DONE : IDLE;
                HDR:     state_d = SHIFT;
                SHIFT:   state_d = TRAIL;
                default: state_d = DONE;
              endcase
              if (state_d == DONE || state_d == IDLE)
                run_d = 1'b0;
              if (state_d == DONE)
                rsp_d = cap_q;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end
        end
      end
    endcase

    // New TMS/TDI take effect with the falling TCK edge.
    if (load) begin
      tdi_d = 1'b0;
      case (state_d)
        INIT:  tms_d = (bit_d < BW'(5));
        HDR:   tms_d = ir_q ? (bit_d < BW'(2)) : (bit_d == '0);
        SHIFT: begin
          tms_d = (bit_d == BW'(len_q));
          tdi_d = data_q[bit_d[LW-1:0]];
        end
        TRAIL:   tms_d = (bit_d == '0);
        default: tms_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= INIT;
      run_q     <= 1'b0;
      cyc_q     <= '0;
      bit_q     <= '0;
      tck       <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      rst_cmd_q <= 1'b0;
      ir_q      <= 1'b0;
      len_q     <= '0;
      data_q    <= '0;
      cap_q     <= '0;
      rsp_data  <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      cyc_q     <= cyc_d;
      bit_q     <= bit_d;
      tck       <= tck_d;
      tms       <= tms_d;
      tdi       <= tdi_d;
      rst_cmd_q <= rst_cmd_d;
      ir_q      <= ir_d;
      len_q     <= len_d;
      data_q    <= data_d;
      cap_q     <= cap_d;
      rsp_data  <= rsp_d;
    end
  end

endmodule

// File: tb/tb_jtag_master.sv
// tb/tb_jtag_master.sv - Self-checking bench for jtag_master with a behavioural TAP target.
module tb_jtag_master;
  localparam int DW = 32;
  localparam int CD = 2;
  localparam int P  = 2 * CD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_reset = 1'b0;
  logic        cmd_ir = 1'b0;
  logic [4:0]  cmd_len = '0;
  logic [31:0] cmd_data = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        tck, tms, tdi;
  logic        tdo = 1'b0;

  jtag_master #(.DWIDTH(DW), .CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_reset(cmd_reset), .cmd_ir(cmd_ir), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc_cnt);
    end
  endtask

  // IEEE 1149.1 target TAP
  typedef enum int {TLR, RTI, SDRS, CDR, SDR, E1DR, PDR, E2DR, UDR,
                    SIRS, CIR, SIR, E1IR, PIR, E2IR, UIR} tap_t;

  function automatic tap_t tap_next(input tap_t s, input logic m);
    case (s)
      TLR:  return m ? TLR  : RTI;
      RTI:  return m ? SDRS : RTI;
      SDRS: return m ? SIRS : CDR;
      CDR:  return m ? E1DR : SDR;
      SDR:  return m ? E1DR : SDR;
      E1DR: return m ? UDR  : PDR;
      PDR:  return m ? E2DR : PDR;
      E2DR: return m ? UDR  : SDR;
      UDR:  return m ? SDRS : RTI;
      SIRS: return m ? TLR  : CIR;
      CIR:  return m ? E1IR : SIR;
      SIR:  return m ? E1IR : SIR;
      E1IR: return m ? UIR  : PIR;
      PIR:  return m ? E2IR : PIR;
      E2IR: return m ? UIR  : SIR;
      default: return m ? SDRS : RTI;
    endcase
  endfunction

  tap_t        tap = PDR;
  logic [31:0] dr_cap = '0, ir_cap = '0, m_dr = '0, m_ir = '0, sh_cap = '0, sh_in = '0;
  int          k = 0;
  bit          saw_tlr = 0;
  int          tck_cnt = 0;
  logic [63:0] tms_rec = '0;

  always @(posedge tck) begin
    case (tap)
      CDR:  begin sh_cap <= dr_cap; sh_in <= '0; k <= 0; end
      CIR:  begin sh_cap <= ir_cap; sh_in <= '0; k <= 0; end
      SDR, SIR: begin if (k < 32) sh_in[k] <= tdi; k <= k + 1; end
      UDR:  m_dr <= sh_in;
      UIR:  m_ir <= sh_in;
      default: ;
    endcase
    if (tap_next(tap, tms) == TLR) saw_tlr = 1;
    tap <= tap_next(tap, tms);
    tck_cnt = tck_cnt + 1;
    tms_rec = {tms_rec[62:0], tms};
  end

  always @(negedge tck) tdo <= ((tap == SDR || tap == SIR) && k < 32) ? sh_cap[k] : 1'b0;

  // Expected per-TCK pin values for the command in flight, plus response bookkeeping
  int          t_acc = 0;
  int          exp_n = 0;
  bit          exp_has_rsp = 0;
  logic [31:0] exp_rsp = '0, exp_hold = '0;
  bit          exp_tms [64];
  bit          exp_tdi [64];
  bit          chk_en = 0;

  always begin : cmp
    int rel, t_end, b, ph;
    @(posedge clk);
    #1;
    if (chk_en) begin
      rel   = cyc_cnt - t_acc;
      t_end = exp_n * P;
      if (rel >= 1 && rel <= t_end) begin
        b  = (rel - 1) / P;
        ph = (rel - 1) % P;
        chk("tck", tck, (ph >= CD) ? 1 : 0);
        chk("tms", tms, exp_tms[b]);
        chk("tdi", tdi, exp_tdi[b]);
        chk("busy_ready", cmd_ready, 0);
        chk("busy_rsp_valid", rsp_valid, 0);
        chk("rsp_hold", rsp_data, exp_hold);
      end else if (rel == t_end + 1 && exp_has_rsp) begin
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_data", rsp_data, exp_rsp);
        chk("done_ready", cmd_ready, 0);
        chk("done_tck", tck, 0);
        exp_hold = exp_rsp;
      end else begin
        chk("idle_ready", cmd_ready, 1);
        chk("idle_rsp_valid", rsp_valid, 0);
        chk("idle_tck", tck, 0);
        chk("idle_tms", tms, 0);
        chk("idle_tdi", tdi, 0);
        chk("idle_rsp_hold", rsp_data, exp_hold);
      end
    end
  end

  task automatic release_init();
    rst = 1'b0;
    exp_n = 6;
    for (int i = 0; i < 6; i++) begin exp_tms[i] = (i < 5); exp_tdi[i] = 0; end
    exp_has_rsp = 0;
    exp_hold = '0;
    t_acc = cyc_cnt;
    tck_cnt = 0;
    tms_rec = '0;
    saw_tlr = 0;
    chk_en = 1;
    repeat (24) @(negedge clk);
    chk("init_ready_c24", cmd_ready, 0);
    @(negedge clk);
    chk("init_ready_c25", cmd_ready, 1);
    chk("init_tck_count", tck_cnt, 6);
    chk("init_tms_seq", tms_rec, 64'h3E);
    chk("init_tlr", saw_tlr, 1);
    chk("init_tap_rti", 64'(tap), 64'(RTI));
  endtask

  task automatic start_cmd(input bit rc, input bit ir, input int len, input logic [31:0] data);
    int w, n;
    logic [63:0] m;
    w = 0;
    while (!cmd_ready && w < 500) begin @(negedge clk); w++; end
    chk("ready_wait", cmd_ready, 1);
    n = 0;
    if (rc) begin
      for (int i = 0; i < 6; i++) begin exp_tms[n] = (i < 5); exp_tdi[n] = 0; n++; end
    end else begin
      exp_tms[n] = 1; exp_tdi[n] = 0; n++;
      if (ir) begin exp_tms[n] = 1; exp_tdi[n] = 0; n++; end
      exp_tms[n] = 0; exp_tdi[n] = 0; n++;
      exp_tms[n] = 0; exp_tdi[n] = 0; n++;
      for (int i = 0; i <= len; i++) begin exp_tms[n] = (i == len); exp_tdi[n] = data[i]; n++; end
      exp_tms[n] = 1; exp_tdi[n] = 0; n++;
      exp_tms[n] = 0; exp_tdi[n] = 0; n++;
    end
    m = (64'd1 << (len + 1)) - 64'd1;
    exp_rsp = rc ? 32'h0 : ((ir ? ir_cap : dr_cap) & m[31:0]);
    cmd_valid = 1'b1;
    cmd_reset = rc;
    cmd_ir = ir;
    cmd_len = 5'(len);
    cmd_data = data;
    t_acc = cyc_cnt;
    exp_n = n;
    exp_has_rsp = 1;
    tck_cnt = 0;
    tms_rec = '0;
    saw_tlr = 0;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_reset = ~rc;
    cmd_ir = ~ir;
    cmd_data = ~data;
  endtask

  task automatic run_cmd(input bit rc, input bit ir, input int len, input logic [31:0] data,
                         input bit pulse_mid, input int lat_lit, input int tck_lit,
                         input logic [63:0] tms_lit, input logic [31:0] rsp_lit);
    int lat;
    start_cmd(rc, ir, len, data);
    lat = -1;
    for (int c = 0; c < 400 && lat < 0; c++) begin
      if (rsp_valid) lat = cyc_cnt - t_acc;
      else begin
        cmd_valid = pulse_mid && (c >= 40 && c < 43);
        @(negedge clk);
      end
    end
    cmd_valid = 1'b0;
    chk("latency", 64'(lat), 64'(lat_lit));
    chk("tck_count", tck_cnt, tck_lit);
    chk("tms_seq", tms_rec, tms_lit);
    chk("rsp_literal", rsp_data, rsp_lit);
    chk("tlr_seen", saw_tlr, rc);
    @(negedge clk);
    chk("tap_rti", 64'(tap), 64'(RTI));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tck", tck, 0);
    chk("rst_tms", tms, 1);
    chk("rst_tdi", tdi, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    release_init();

    dr_cap = 32'hFFFF_FF3C;
    run_cmd(0, 0, 7, 32'hA5, 0, 53, 13, 64'h1006, 32'h3C);
    chk("dr_model_a5", m_dr, 32'hA5);

    ir_cap = 32'h5;
    run_cmd(0, 1, 3, 32'h9, 0, 41, 10, 64'h306, 32'h5);
    chk("ir_model_9", m_ir, 32'h9);

    dr_cap = 32'hFFFF_FFFF;
    run_cmd(0, 0, 0, 32'h1, 0, 25, 6, 64'h26, 32'h1);
    chk("dr_model_1", m_dr, 32'h1);

    dr_cap = 32'h1234_5678;
    run_cmd(0, 0, 31, 32'hDEAD_BEEF, 1, 149, 37, 64'h10_0000_0006, 32'h1234_5678);
    chk("dr_model_full", m_dr, 32'hDEAD_BEEF);

    run_cmd(1, 0, 0, 32'hFFFF_FFFF, 0, 25, 6, 64'h3E, 32'h0);

    // Reset during SHIFT bit 3 of an 8-bit DR scan
    dr_cap = 32'hFF;
    start_cmd(0, 0, 7, 32'h5A);
    repeat (25) @(negedge clk);
    chk_en = 0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_tck", tck, 0);
    chk("mid_rst_tms", tms, 1);
    chk("mid_rst_tdi", tdi, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    release_init();

    dr_cap = 32'hFA;
    run_cmd(0, 0, 3, 32'h6, 0, 37, 9, 64'h106, 32'hA);
    chk("dr_model_6", m_dr, 32'h6);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
